// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock-divider controller.
// Generates a glitch-free, duty-controlled strobe clk_out whose period and high
// time are counted in clk cycles. New {period, high} pairs arrive through a
// valid/ready handshake into a shadow register. They are promoted to the active
// pair only at a period boundary, or immediately while idle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | output parked low, waiting for enable with a loaded config
// RUN   | counting periods, period_tick on every wrap
// STOP  | enable dropped, finishing the current period before parking
module clk_div_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             period_tick,
  output logic             cfg_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] shd_period_q, shd_period_d;
  logic [CNT_W-1:0] shd_high_q, shd_high_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             period_tick_q, period_tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

  logic             cfg_acc;
  logic             cfg_legal;
  logic             configured;
  logic             cnt_wrap;
  logic [CNT_W-1:0] next_cnt;
  logic [CNT_W-1:0] next_high;

  assign cfg_ready   = !pend_q;
  assign cfg_acc     = cfg_valid && !pend_q;
  assign cfg_legal   = (cfg_period >= CNT_TWO) && (cfg_high >= CNT_ONE) &&
                       (cfg_high < cfg_period);
  assign configured  = (act_period_q != CNT_ZERO);
  // Only meaningful in RUN/STOP, where act_period_q >= 2 is guaranteed.
  assign cnt_wrap    = (cnt_q == (act_period_q - CNT_ONE));

  assign clk_out     = clk_out_q;
  assign period_tick = period_tick_q;
  assign cfg_err     = cfg_err_q;
  assign busy        = busy_q;

  // Next-state, counter, config promotion and output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    shd_period_d  = shd_period_q;
    shd_high_d    = shd_high_q;
    pend_d        = pend_q;
    clk_out_d     = clk_out_q;
    period_tick_d = 1'b0;
    cfg_err_d     = 1'b0;
    next_cnt      = CNT_ZERO;
    next_high     = act_high_q;

    // Accept only happens while pend_q is clear, so it never collides with
    // the promotions below, which all require pend_q set.
    if (cfg_acc) begin
      if (cfg_legal) begin
        shd_period_d = cfg_period;
        shd_high_d   = cfg_high;
        pend_d       = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          act_period_d = shd_period_q;
          act_high_d   = shd_high_q;
          pend_d       = 1'b0;
        end
        cnt_d = CNT_ZERO;
        if (enable && configured) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
        end else begin
          clk_out_d = 1'b0;
        end
      end

      ST_RUN, ST_STOP: begin
        next_cnt = cnt_wrap ? CNT_ZERO : (cnt_q + CNT_ONE);
        if (cnt_wrap && pend_q) begin
          act_period_d = shd_period_q;
          act_high_d   = shd_high_q;
          pend_d       = 1'b0;
          next_high    = shd_high_q;
        end
        cnt_d     = next_cnt;
        clk_out_d = (next_cnt < next_high);

        if (state_q == ST_RUN) begin
          period_tick_d = cnt_wrap;
          if (!enable) begin
            state_d = ST_STOP;
          end
        end else begin
          // A re-enable wins over parking so the waveform keeps its phase.
          if (enable) begin
            state_d = ST_RUN;
          end else if (cnt_wrap) begin
            state_d   = ST_IDLE;
            cnt_d     = CNT_ZERO;
            clk_out_d = 1'b0;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        clk_out_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      act_period_q  <= CNT_ZERO;
      act_high_q    <= CNT_ZERO;
      shd_period_q  <= CNT_ZERO;
      shd_high_q    <= CNT_ZERO;
      pend_q        <= 1'b0;
      clk_out_q     <= 1'b0;
      period_tick_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      shd_period_q  <= shd_period_d;
      shd_high_q    <= shd_high_d;
      pend_q        <= pend_d;
      clk_out_q     <= clk_out_d;
      period_tick_q <= period_tick_d;
      cfg_err_q     <= cfg_err_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Synthesizable programmable clock-divider controller: it produces a clock-enable-style waveform `clk_out` with a run-time programmable period and high time, both counted in `clk` cycles. Software or a test sequencer loads `{period, high}` pairs through a valid/ready handshake. New settings take effect only at a period boundary, so `clk_out` never glitches. The block sits between the configuration master and any logic that needs a derived, duty-cycle-controlled strobe or clock.

## Interface
- `CNT_W`, default 16: width of the period/high counters and config fields.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `enable` input 1: run request; level-sensitive.
- `cfg_valid` input 1: config offer.
- `cfg_ready` output 1: shadow register free; accept occurs when `cfg_valid && cfg_ready`.
- `cfg_period` input `CNT_W`: period in `clk` cycles.
- `cfg_high` input `CNT_W`: number of high cycles per period.
- `clk_out` output 1: generated waveform, registered.
- `period_tick` output 1: one-cycle pulse on the first cycle of every new period after the first.
- `cfg_err` output 1: one-cycle pulse, the cycle after an illegal config is offered and dropped.
- `busy` output 1: high in RUN or STOP.

## Operation
- Registers:
  - active pair `act_period`/`act_high`;
  - shadow pair plus `pend` flag;
  - counter `cnt`;
  - state.
- Reset: state = IDLE, `cnt` = 0, `act_*` = 0, `pend` = 0, `clk_out` = 0, `period_tick` = 0, `cfg_err` = 0, `busy` = 0.
- `cfg_ready` = `!pend`.
- Legality on accept: `cfg_period >= 2`, `cfg_high >= 1`, `cfg_high < cfg_period`.
  - Legal: load shadow, set `pend`.
  - Illegal: shadow untouched, `cfg_err` = 1 next cycle.
- A pending shadow is promoted to active (and `pend` cleared) in two cases:
  - in IDLE: on the next edge;
  - in RUN/STOP: only on the wrap edge.
- `configured` = `act_period != 0`.
- States:
  - IDLE:
    - `enable && configured` → RUN, with `cnt` <= 0 and `clk_out` <= 1.
    - Otherwise stay IDLE with `clk_out` = 0.
  - RUN:
    - Each edge: `cnt` <= `cnt + 1`, or 0 when `cnt == act_period-1` (wrap).
    - `clk_out` <= (`next_cnt < next_high`), where `next_high` is the post-promotion value on a wrap edge.
    - `!enable` → STOP (counting continues).
  - STOP:
    - Counts identically to RUN.
    - On wrap → IDLE, `cnt` <= 0, `clk_out` <= 0; the current period completes fully.
    - `enable` reasserted before the wrap → RUN, with no gap or phase change.
- `period_tick` <= 1 on every wrap edge taken in RUN; 0 otherwise. No tick is generated on the STOP→IDLE wrap.
- Width rules:
  - `cnt` is `CNT_W` bits and never exceeds `act_period-1`.
  - Comparisons are unsigned.
- Simultaneous events:
  - An accept on the same edge as a wrap loads the shadow only. It is promoted at the next wrap.
  - Promotion and acceptance cannot overlap, because `cfg_ready` = 0 while `pend` = 1.

## Timing
- Enable latency: `enable` sampled high in IDLE → `clk_out` = 1 on the following cycle. This is 1 cycle of latency.
- Per period in steady state: `clk_out` is high for exactly `act_high` cycles, then low for `act_period - act_high` cycles.
- Config latency:
  - IDLE: accept at edge N → active at edge N+1.
  - RUN: accept → active at the next wrap edge. Worst case is `act_period` cycles.
- `cfg_err` is asserted 1 cycle after the offending accept edge, for exactly 1 cycle.
- Stop latency: `clk_out` returns to 0 after at most `act_period` cycles. The final value of `clk_out` is always 0.
- Reset mid-operation: the state listed under Operation is reached on the first edge with `rst_n` = 0.
  - The active config is lost, so the block must be reconfigured.
  - An offer present during reset is ignored.

## Test plan
- Basic:
  - Stimulus: reset, load period=10/high=2, `enable`=1.
  - Required: `clk_out` pattern `1100000000` repeating (20% duty); `period_tick` every 10 cycles; `busy`=1.
- Mid-run reconfiguration:
  - Stimulus: while running 10/2, at `cnt`=4 load period=4/high=2.
  - Required:
    - the current period finishes as 10/2;
    - then `1100` repeating;
    - `cfg_ready` stays low from accept until the wrap.
- Illegal configs:
  - Stimulus: offer 1/0, 5/5 and 5/0 in turn.
  - Required: each offer gives a `cfg_err` pulse 1 cycle later; the active config is unchanged; the waveform is undisturbed.
- Stop/restart:
  - Stimulus: drop `enable` at `cnt`=1 of 10/2.
  - Required: the period runs to `cnt`=9, then `clk_out`=0 and state IDLE, with no tick.
  - Stimulus: in a second run, reassert `enable` at `cnt`=5.
  - Required: the waveform continues seamlessly.
- Enable before config:
  - Stimulus: `enable`=1 with no config loaded.
  - Required: remains IDLE with `clk_out`=0.
  - Stimulus: load 3/1.
  - Required: `clk_out`=1 two edges after the accept edge (one edge to promote, one to enter RUN), then `100` repeating.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 for 1 cycle at `cnt`=3 of 10/2.
  - Required: all outputs 0 and `cfg_ready`=1 the next cycle; `enable`=1 alone does not restart the block.
